// File: rtl/core_decode.sv
// RV32I decode stage: turns one fetched instruction plus its register operands into an ALU
// payload and holds it in a two-entry skid buffer, so the ready signal back to fetch is registered.
module core_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_src1,
    output logic [XLEN-1:0] ex_src2,
    output logic [3:0]      ex_alu_op,
    output logic [2:0]      ex_brnch_cnd,
    output logic            ex_brnch_inv,
    output logic            ex_jump,
    output logic            ex_ls,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic            ex_illegal
);
    // ALU and branch-condition codes shared with core_alu
    localparam logic [3:0] ADD_ALU  = 4'd0;
    localparam logic [3:0] SUB_ALU  = 4'd1;
    localparam logic [3:0] SLL_ALU  = 4'd2;
    localparam logic [3:0] SLT_ALU  = 4'd3;
    localparam logic [3:0] SLTU_ALU = 4'd4;
    localparam logic [3:0] XOR_ALU  = 4'd5;
    localparam logic [3:0] SRL_ALU  = 4'd6;
    localparam logic [3:0] SRA_ALU  = 4'd7;
    localparam logic [3:0] OR_ALU   = 4'd8;
    localparam logic [3:0] AND_ALU  = 4'd9;
    localparam logic [2:0] ALU_BEQ  = 3'b100;
    localparam logic [2:0] ALU_BNE  = 3'b101;
    localparam logic [2:0] ALU_BLT  = 3'b110;
    localparam logic [2:0] ALU_BLTU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [3:0]      alu_op;
        logic [2:0]      brnch_cnd;
        logic            brnch_inv;
        logic            jump;
        logic            ls;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } payload_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t   state_reg, state_next;
    payload_t main_reg, skid_reg, dec;
    logic     if_ready_reg;
    logic     accept, take, load_main_dec, load_main_skid, load_skid;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic            writes_rd;

    assign opcode      = if_instr[6:0];
    assign rd          = if_instr[11:7];
    assign f3          = if_instr[14:12];
    assign f7          = if_instr[31:25];
    assign rf_rs1_addr = if_instr[19:15];
    assign rf_rs2_addr = if_instr[24:20];
    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};

    always_comb begin
        dec           = '0;
        dec.src1      = rf_rs1_data;
        dec.src2      = rf_rs2_data;
        dec.alu_op    = ADD_ALU;
        dec.pc        = if_pc;
        dec.rd        = rd;
        writes_rd     = 1'b0;
        case (opcode)
            7'b0110011: begin
                writes_rd = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: dec.alu_op = ADD_ALU;
                    10'b0100000_000: dec.alu_op = SUB_ALU;
                    10'b0000000_001: dec.alu_op = SLL_ALU;
                    10'b0000000_010: dec.alu_op = SLT_ALU;
                    10'b0000000_011: dec.alu_op = SLTU_ALU;
                    10'b0000000_100: dec.alu_op = XOR_ALU;
                    10'b0000000_101: dec.alu_op = SRL_ALU;
                    10'b0100000_101: dec.alu_op = SRA_ALU;
                    10'b0000000_110: dec.alu_op = OR_ALU;
                    10'b0000000_111: dec.alu_op = AND_ALU;
                    default:         dec.illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                writes_rd = 1'b1;
                dec.src2  = imm_i;
                dec.imm   = imm_i;
                case (f3)
                    3'b000: dec.alu_op = ADD_ALU;
                    3'b010: dec.alu_op = SLT_ALU;
                    3'b011: dec.alu_op = SLTU_ALU;
                    3'b100: dec.alu_op = XOR_ALU;
                    3'b110: dec.alu_op = OR_ALU;
                    3'b111: dec.alu_op = AND_ALU;
                    default: begin
                        // shifts take only the 5-bit shamt; f7 selects logical/arithmetic
                        dec.src2 = {27'b0, if_instr[24:20]};
                        if (f7 == 7'b0000000)
                            dec.alu_op = (f3 == 3'b001) ? SLL_ALU : SRL_ALU;
                        else if (f7 == 7'b0100000 && f3 == 3'b101)
                            dec.alu_op = SRA_ALU;
                        else
                            dec.illegal = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                writes_rd = 1'b1;
                dec.src1  = '0;
                dec.src2  = imm_u;
                dec.imm   = imm_u;
            end
            7'b0010111: begin
                writes_rd = 1'b1;
                dec.src1  = if_pc;
                dec.src2  = imm_u;
                dec.imm   = imm_u;
            end
            7'b1100011: begin
                dec.imm = imm_b;
                case (f3)
                    3'b000: dec.brnch_cnd = ALU_BEQ;
                    3'b001: dec.brnch_cnd = ALU_BNE;
                    3'b100: dec.brnch_cnd = ALU_BLT;
                    3'b101: begin dec.brnch_cnd = ALU_BLT;  dec.brnch_inv = 1'b1; end
                    3'b110: dec.brnch_cnd = ALU_BLTU;
                    3'b111: begin dec.brnch_cnd = ALU_BLTU; dec.brnch_inv = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b1101111, 7'b1100111: begin
                writes_rd = 1'b1;
                dec.src1  = if_pc;
                dec.src2  = 32'd4;
                dec.jump  = 1'b1;
                dec.imm   = opcode[3] ? imm_j : imm_i;
                if (!opcode[3] && f3 != 3'b000) dec.illegal = 1'b1;
            end
            7'b0000011: begin
                writes_rd = 1'b1;
                dec.src2  = imm_i;
                dec.imm   = imm_i;
                dec.ls    = 1'b1;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) dec.illegal = 1'b1;
            end
            7'b0100011: begin
                dec.src2 = imm_s;
                dec.imm  = imm_s;
                dec.ls   = 1'b1;
                if (f3[2] || f3 == 3'b011) dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // an illegal word still travels to EX, but as an inert ADD with no side effects
        if (dec.illegal) begin
            dec.alu_op    = ADD_ALU;
            dec.brnch_cnd = 3'b000;
            dec.brnch_inv = 1'b0;
            dec.jump      = 1'b0;
            dec.ls        = 1'b0;
        end
        dec.rd_we = writes_rd && !dec.illegal && (rd != 5'd0);
    end

    assign ex_valid = (state_reg != EMPTY);
    assign if_ready = if_ready_reg;
    assign accept   = if_valid && if_ready_reg;
    assign take     = ex_valid && ex_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: if (accept) begin
                    state_next    = ONE;
                    load_main_dec = 1'b1;
                end
                ONE: begin
                    if (accept && take) begin
                        load_main_dec = 1'b1;
                    end else if (accept) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (take) begin
                        state_next = EMPTY;
                    end
                end
                FULL: if (take) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            if_ready_reg <= 1'b1;
            main_reg     <= '0;
            skid_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            if_ready_reg <= (state_next != FULL);
            if (load_main_dec)       main_reg <= dec;
            else if (load_main_skid) main_reg <= skid_reg;
            if (load_skid)           skid_reg <= dec;
        end
    end

    assign ex_src1      = main_reg.src1;
    assign ex_src2      = main_reg.src2;
    assign ex_alu_op    = main_reg.alu_op;
    assign ex_brnch_cnd = main_reg.brnch_cnd;
    assign ex_brnch_inv = main_reg.brnch_inv;
    assign ex_jump      = main_reg.jump;
    assign ex_ls        = main_reg.ls;
    assign ex_imm       = main_reg.imm;
    assign ex_pc        = main_reg.pc;
    assign ex_rd        = main_reg.rd;
    assign ex_rd_we     = main_reg.rd_we;
    assign ex_illegal   = main_reg.illegal;
endmodule

// File: tb/tb_core_decode.sv
// Directed bench for core_decode: hand-encoded instructions, fixed register file contents,
// immediate-assertion checks after each clock step.
module tb_core_decode;
    logic        clk = 1'b0;
    logic        rst_n, if_valid, if_ready, flush, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, rf_rs1_data, rf_rs2_data;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr, ex_rd;
    logic [31:0] ex_src1, ex_src2, ex_imm, ex_pc;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_brnch_cnd;
    logic        ex_brnch_inv, ex_jump, ex_ls, ex_rd_we, ex_illegal;
    logic [31:0] rf [32];
    int          tests = 0;
    int          fails = 0;

    localparam logic [31:0] ADD_ALU = 0, SRA_ALU = 7, ALU_BLTU = 3'b111;

    core_decode #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_alu_op(ex_alu_op), .ex_brnch_cnd(ex_brnch_cnd), .ex_brnch_inv(ex_brnch_inv),
        .ex_jump(ex_jump), .ex_ls(ex_ls), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'd0 : rf[rf_rs1_addr];
        rf_rs2_data = (rf_rs2_addr == 5'd0) ? 32'd0 : rf[rf_rs2_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b0;
        tick(); tick();
        $display("[TB] reset state");
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
        chk("rst_ex_src1", ex_src1, 32'd0);
        chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD x3,x1,x2
        ex_ready = 1'b1;
        send(32'h002081B3, 32'h100);
        #1;
        chk("add_rs1_addr", {27'b0, rf_rs1_addr}, 32'd1);
        chk("add_rs2_addr", {27'b0, rf_rs2_addr}, 32'd2);
        tick();
        if_valid = 1'b0;
        $display("[TB] ADD x3,x1,x2");
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_src1", ex_src1, 32'd5);
        chk("add_src2", ex_src2, 32'd7);
        chk("add_op", {28'b0, ex_alu_op}, ADD_ALU);
        chk("add_rd", {27'b0, ex_rd}, 32'd3);
        chk("add_we", {31'b0, ex_rd_we}, 32'd1);
        chk("add_pc", ex_pc, 32'h100);
        tick();
        chk("add_drain", {31'b0, ex_valid}, 32'd0);

        // back-pressure: three offered, two accepted
        ex_ready = 1'b0;
        send(32'h00208233, 32'h200);
        tick();
        chk("bp_ready_one", {31'b0, if_ready}, 32'd1);
        send(32'h002082B3, 32'h204);
        tick();
        $display("[TB] back-pressure full");
        chk("bp_ready_full", {31'b0, if_ready}, 32'd0);
        chk("bp_rd_a", {27'b0, ex_rd}, 32'd4);
        send(32'h00208333, 32'h208);
        tick();
        chk("bp_frozen_rd", {27'b0, ex_rd}, 32'd4);
        chk("bp_frozen_pc", ex_pc, 32'h200);
        chk("bp_frozen_valid", {31'b0, ex_valid}, 32'd1);
        if_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        $display("[TB] back-pressure drain");
        chk("bp_rd_b", {27'b0, ex_rd}, 32'd5);
        chk("bp_pc_b", ex_pc, 32'h204);
        chk("bp_ready_back", {31'b0, if_ready}, 32'd1);
        tick();
        chk("bp_empty", {31'b0, ex_valid}, 32'd0);

        // BGEU x1,x2,-8
        send(32'hFE20FCE3, 32'h300);
        tick();
        if_valid = 1'b0;
        $display("[TB] BGEU");
        chk("bgeu_cnd", {29'b0, ex_brnch_cnd}, ALU_BLTU);
        chk("bgeu_inv", {31'b0, ex_brnch_inv}, 32'd1);
        chk("bgeu_we", {31'b0, ex_rd_we}, 32'd0);
        chk("bgeu_imm", ex_imm, 32'hFFFFFFF8);
        tick();

        // SRAI x5,x6,3
        send(32'h40335293, 32'h304);
        tick();
        $display("[TB] SRAI");
        chk("srai_op", {28'b0, ex_alu_op}, SRA_ALU);
        chk("srai_shamt", {27'b0, ex_src2[4:0]}, 32'd3);
        chk("srai_legal", {31'b0, ex_illegal}, 32'd0);
        // SLLI slot with f7=0100000
        send(32'h40331293, 32'h308);
        tick();
        if_valid = 1'b0;
        $display("[TB] bad SLLI");
        chk("slli_illegal", {31'b0, ex_illegal}, 32'd1);
        chk("slli_we", {31'b0, ex_rd_we}, 32'd0);
        chk("slli_valid", {31'b0, ex_valid}, 32'd1);
        tick();

        // JAL x1,+8 and SW x2,12(x1)
        send(32'h008000EF, 32'h400);
        tick();
        $display("[TB] JAL");
        chk("jal_src1", ex_src1, 32'h400);
        chk("jal_src2", ex_src2, 32'd4);
        chk("jal_jump", {31'b0, ex_jump}, 32'd1);
        chk("jal_imm", ex_imm, 32'd8);
        send(32'h0020A623, 32'h404);
        tick();
        if_valid = 1'b0;
        $display("[TB] SW");
        chk("sw_src1", ex_src1, 32'd5);
        chk("sw_src2", ex_src2, 32'd12);
        chk("sw_ls", {31'b0, ex_ls}, 32'd1);
        chk("sw_we", {31'b0, ex_rd_we}, 32'd0);
        tick();

        // flush of a FULL buffer while fetch keeps offering
        ex_ready = 1'b0;
        send(32'h00208233, 32'h500);
        tick();
        send(32'h002082B3, 32'h504);
        tick();
        chk("fl_full", {31'b0, if_ready}, 32'd0);
        flush = 1'b1;
        send(32'h00208333, 32'h508);
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        $display("[TB] flush from FULL");
        chk("fl_valid", {31'b0, ex_valid}, 32'd0);
        chk("fl_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("fl_stays_empty", {31'b0, ex_valid}, 32'd0);
        // flush in ONE discards a same-cycle accept
        send(32'h00208233, 32'h600);
        tick();
        flush = 1'b1;
        send(32'h002082B3, 32'h604);
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        $display("[TB] flush from ONE");
        chk("fl1_valid", {31'b0, ex_valid}, 32'd0);
        tick();
        chk("fl1_discard", {31'b0, ex_valid}, 32'd0);

        // ADDI x0,x0,1 then LUI x1,0x12345
        ex_ready = 1'b1;
        send(32'h00100013, 32'h700);
        tick();
        $display("[TB] ADDI x0");
        chk("addi_we", {31'b0, ex_rd_we}, 32'd0);
        chk("addi_src2", ex_src2, 32'd1);
        send(32'h123450B7, 32'h704);
        tick();
        if_valid = 1'b0;
        $display("[TB] LUI");
        chk("lui_src2", ex_src2, 32'h12345000);
        chk("lui_src1", ex_src1, 32'd0);
        chk("lui_we", {31'b0, ex_rd_we}, 32'd1);

        // asynchronous reset while holding a word
        ex_ready = 1'b0;
        send(32'h002081B3, 32'h800);
        tick();
        if_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset mid-transfer");
        chk("arst_valid", {31'b0, ex_valid}, 32'd0);
        chk("arst_rd", {27'b0, ex_rd}, 32'd0);
        chk("arst_ready", {31'b0, if_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
